aoi_path_sequencer: RTL

//  Sequences measurements on the 4-input AND-OR path, y = (a&b)|(c&d).
//  Per request: launch a registered vector onto the path, wait a programmable settle time
//    so the gate/path delays resolve, capture y, compare it to the expected value and return the result.

---
 rtl/aoi_path_sequencer_pkg.sv | 18 +
 rtl/aoi_path_sequencer_settle_counter.sv | 31 +++
 rtl/aoi_path_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aoi_path_sequencer_pkg.sv
// Shared types and helpers for the AND-OR path measurement sequencer.
// Holds the FSM state encoding and the reference model of the path under test.
package aoi_path_sequencer_pkg;

  localparam int unsigned VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Expected value of y = (a&b)|(c&d) for a vector packed as {a,b,c,d}
  function automatic logic aoi_exp(input logic [VEC_W-1:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

endpackage

// File: rtl/aoi_path_sequencer_settle_counter.sv
// Down-counter timing the settle window of one measurement.
// A load value of 0 is promoted to 1 so every measurement waits at least one cycle.
module aoi_path_sequencer_settle_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_val;

  assign w_load_val = (i_load_val == '0) ? CNT_W'(1) : i_load_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/aoi_path_sequencer.sv
// Launches a vector onto the AND-OR path, waits the configured settle time,
// captures y, compares against the expected value and reports the result.
module aoi_path_sequencer
  import aoi_path_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [VEC_W-1:0] i_req_vec,
  input  logic [CNT_W-1:0] i_cfg_settle,
  input  logic             i_abort,
  output logic             o_path_a,
  output logic             o_path_b,
  output logic             o_path_c,
  output logic             o_path_d,
  input  logic             i_path_y,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_y,
  output logic             o_rsp_exp,
  output logic             o_rsp_err,
  output logic [ERR_W-1:0] o_err_cnt,
  input  logic             i_err_clr
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_dec;
  logic             w_last;
  logic             w_mismatch;
  logic [VEC_W-1:0] r_path;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_y;
  logic             r_rsp_exp;
  logic             r_rsp_err;
  logic [ERR_W-1:0] r_err_cnt;

  aoi_path_sequencer_settle_counter #(.CNT_W(CNT_W)) u_settle_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_load_val (i_cfg_settle),
    .i_dec      (w_dec),
    .o_last_c   (w_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Abort outranks capture in SETTLE; RESP ignores abort entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_req_valid) w_next = ST_SETTLE;
      ST_SETTLE: begin
        if (i_abort)     w_next = ST_IDLE;
        else if (w_last) w_next = ST_RESP;
      end
      ST_RESP:   if (i_rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_dec     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE:   w_accept = i_req_valid;
      ST_SETTLE: begin
        w_dec     = 1'b1;
        w_capture = w_last && !i_abort;
      end
      default: ;
    endcase
  end

  assign w_mismatch = (i_path_y != r_rsp_exp);

  // Handshake flags are registered copies of the next-state decode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_path      <= '0;
      r_rsp_y     <= 1'b0;
      r_rsp_exp   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_req_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_path    <= i_req_vec;
        r_rsp_exp <= aoi_exp(i_req_vec);
      end
      if (w_capture) begin
        r_rsp_y   <= i_path_y;
        r_rsp_err <= w_mismatch;
      end
      if (i_err_clr) begin
        r_err_cnt <= '0;
      end else if (w_capture && w_mismatch && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_path_a    = r_path[3];
  assign o_path_b    = r_path[2];
  assign o_path_c    = r_path[1];
  assign o_path_d    = r_path[0];
  assign o_rsp_y     = r_rsp_y;
  assign o_rsp_exp   = r_rsp_exp;
  assign o_rsp_err   = r_rsp_err;
  assign o_err_cnt   = r_err_cnt;

endmodule
